// File: rtl/sym_vn_lut_loader_pkg.sv
// Shared types and defaults for the symmetric VN LUT loader
// and the read-side scheduler that consumes its status.
package sym_vn_lut_loader_pkg;

   localparam int ENTRY_W_DEF = 4;
   localparam int PAGE_AW_DEF = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } lut_state_e;

endpackage

// File: rtl/sym_vn_lut_loader.sv
// Streams one LUT set into the paired VN rank banks and
// tracks which decoding-iteration set the RAM currently holds.
module sym_vn_lut_loader
   import sym_vn_lut_loader_pkg::*;
#(
   parameter int ENTRY_W = ENTRY_W_DEF,
   parameter int PAGE_AW = PAGE_AW_DEF
) (
   input  logic                 write_clk,
   input  logic                 rst,
   input  logic                 load_start,
   input  logic [3:0]           load_iter,
   input  logic                 abort,
   input  logic                 in_valid,
   input  logic [2*ENTRY_W-1:0] in_data,
   output logic                 in_ready,
   output logic [ENTRY_W-1:0]   lut_in_bank0,
   output logic [ENTRY_W-1:0]   lut_in_bank1,
   output logic [PAGE_AW-1:0]   page_write_addr,
   output logic                 write_addr_offset,
   output logic                 we,
   output logic                 busy,
   output logic                 load_done,
   output logic                 lut_valid,
   output logic [3:0]           iter_loaded
);

   localparam int CNT_W = PAGE_AW + 1;
   localparam logic [CNT_W-1:0] LAST = '1;

   lut_state_e       state;
   lut_state_e       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       iter_lat;
   logic             we_q;
   logic             accept;
   logic             start_ok;
   logic             last_beat;

   assign start_ok  = (state == ST_IDLE) && load_start && !abort;
   assign accept    = in_valid && in_ready;
   assign last_beat = accept && (cnt == LAST);

   // abort kills the registered write and the done pulse
   // in the same cycle so nothing reaches the banks after it
   assign busy      = (state != ST_IDLE);
   assign load_done = (state == ST_DONE) && !abort;
   assign we        = we_q && !abort;

   // next-state and handshake decode
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start_ok)
               state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            in_ready = !abort;
            if (abort)
               state_nxt = ST_IDLE;
            else if (last_beat)
               state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // state register and beat counter
   always_ff @(posedge write_clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (start_ok)
            cnt <= '0;
         else if (accept)
            cnt <= cnt + 1'b1;
      end
   end

   // one-cycle-delayed write port; data/address hold between beats
   always_ff @(posedge write_clk or posedge rst) begin
      if (rst) begin
         we_q              <= 1'b0;
         page_write_addr   <= '0;
         write_addr_offset <= 1'b0;
         lut_in_bank0      <= '0;
         lut_in_bank1      <= '0;
      end else begin
         we_q <= accept;
         if (accept) begin
            {write_addr_offset, page_write_addr} <= cnt;
            lut_in_bank0 <= in_data[ENTRY_W-1:0];
            lut_in_bank1 <= in_data[2*ENTRY_W-1:ENTRY_W];
         end
      end
   end

   // set-valid tracking: invalidate on start, publish after DONE
   always_ff @(posedge write_clk or posedge rst) begin
      if (rst) begin
         lut_valid   <= 1'b0;
         iter_lat    <= '0;
         iter_loaded <= '0;
      end else if (start_ok) begin
         lut_valid <= 1'b0;
         iter_lat  <= load_iter;
      end else if ((state == ST_DONE) && !abort) begin
         lut_valid   <= 1'b1;
         iter_loaded <= iter_lat;
      end
   end

endmodule
